// File: rtl/shift_add_mult.sv
// Sequential unsigned N x N shift-and-add multiplier driving an external combinational adder (s = a + m*b).
// Latency N+1 cycles from accepted start to done; start is only accepted in IDLE and ignored otherwise.
module shift_add_mult #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic [N-1:0]   add_a,
    output logic [N-1:0]   add_b,
    output logic           add_m,
    input  logic [N-1:0]   add_s,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [N-1:0]     p_hi_q;
    logic [N-1:0]     p_lo_q;
    logic [N-1:0]     mcand_q;
    logic [CW-1:0]    count_q;
    logic [2*N-1:0]   product_q;

    logic             carry;
    logic [2*N-1:0]   shift_d;

    // The adder truncates to N bits; a wrap is detectable because add_b < 2^N.
    assign carry   = (add_s < p_hi_q);
    assign shift_d = {carry, add_s, p_lo_q[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            p_hi_q    <= '0;
            p_lo_q    <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q <= a_in;
                        p_hi_q  <= '0;
                        p_lo_q  <= b_in;
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    {p_hi_q, p_lo_q} <= shift_d;
                    count_q          <= count_q + CW'(1);
                    if (count_q == CW'(N - 1)) begin
                        state_q   <= DONE;
                        product_q <= shift_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign add_a   = p_hi_q;
    assign add_b   = mcand_q;
    assign add_m   = p_lo_q[0] & busy;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult at N=4 and N=8, with the external adder modelled behaviourally.
module tb_shift_add_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] add_a4, add_b4, add_s4;
    logic       add_m4, busy4, done4;
    logic [7:0] prod4;

    // N=8 instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] add_a8, add_b8, add_s8;
    logic       add_m8, busy8, done8;
    logic [15:0] prod8;

    assign add_s4 = add_a4 + (add_m4 ? add_b4 : 4'd0);
    assign add_s8 = add_a8 + (add_m8 ? add_b8 : 8'd0);

    shift_add_mult #(.N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4),
        .add_a(add_a4), .add_b(add_b4), .add_m(add_m4), .add_s(add_s4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    shift_add_mult #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
        .add_a(add_a8), .add_b(add_b8), .add_m(add_m8), .add_s(add_s8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    int n_chk = 0;
    int n_pass = 0;

    function automatic logic [3:0] ta(input int c);
        return 4'((c * 5 + 3) % 16);
    endfunction
    function automatic logic [3:0] tb(input int c);
        return 4'((c * 11 + 7) % 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_chk++; if (busy4 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy4); else n_pass++;
        n_chk++; if (done4 !== 1'b0) $display("FAIL reset_done got %b want 0", done4); else n_pass++;
        n_chk++; if (prod4 !== 8'd0) $display("FAIL reset_product got %0d want 0", prod4); else n_pass++;
        n_chk++; if ({add_a4, add_b4, add_m4} !== 9'd0) $display("FAIL reset_adder_ports got %h want 0", {add_a4, add_b4, add_m4}); else n_pass++;
        n_chk++; if (prod8 !== 16'd0) $display("FAIL reset_product8 got %0d want 0", prod8); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // 3 x 5: multiplier bits LSB-first are 1,0,1,0
    task automatic test_basic();
        logic [3:0] mexp;
        mexp = 4'b0101;
        a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
        tick();
        start4 = 1'b0; a4 = 4'd12; b4 = 4'd12;
        n_chk++; if (add_b4 !== 4'd3) $display("FAIL basic_add_b got %0d want 3", add_b4); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (busy4 !== 1'b1) $display("FAIL basic_busy[%0d] got %b want 1", i, busy4); else n_pass++;
            n_chk++; if (add_m4 !== mexp[i]) $display("FAIL basic_add_m[%0d] got %b want %b", i, add_m4, mexp[i]); else n_pass++;
            tick();
        end
        n_chk++; if (done4 !== 1'b1 || busy4 !== 1'b0) $display("FAIL basic_done got done=%b busy=%b want 1/0", done4, busy4); else n_pass++;
        n_chk++; if (prod4 !== 8'd15) $display("FAIL basic_product got %0d want 15", prod4); else n_pass++;
        n_chk++; if (add_m4 !== 1'b0) $display("FAIL basic_add_m_done got %b want 0", add_m4); else n_pass++;
        tick();
        n_chk++; if (done4 !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done4); else n_pass++;
        n_chk++; if (prod4 !== 8'd15) $display("FAIL basic_product_hold got %0d want 15", prod4); else n_pass++;
    endtask

    task automatic test_carry();
        a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (add_m4 !== 1'b1) $display("FAIL carry_add_m[%0d] got %b want 1", i, add_m4); else n_pass++;
            tick();
        end
        n_chk++; if (done4 !== 1'b1) $display("FAIL carry_done got %b want 1", done4); else n_pass++;
        n_chk++; if (prod4 !== 8'hE1) $display("FAIL carry_product got %0d want 225", prod4); else n_pass++;
        tick();
    endtask

    task automatic test_zero();
        logic [3:0] za [2];
        logic [3:0] zb [2];
        int nbusy;
        bit seen;
        za[0] = 4'd0; zb[0] = 4'd9;
        za[1] = 4'd9; zb[1] = 4'd0;
        for (int k = 0; k < 2; k++) begin
            a4 = za[k]; b4 = zb[k]; start4 = 1'b1;
            tick();
            start4 = 1'b0;
            nbusy = 0; seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                if (done4) seen = 1'b1;
                else begin
                    if (busy4) nbusy++;
                    tick();
                end
            end
            n_chk++; if (!seen) $display("FAIL zero_timeout[%0d] got no done want done within 10 cycles", k); else n_pass++;
            n_chk++; if (nbusy !== 4) $display("FAIL zero_busy_cycles[%0d] got %0d want 4", k, nbusy); else n_pass++;
            n_chk++; if (prod4 !== 8'd0) $display("FAIL zero_product[%0d] got %0d want 0", k, prod4); else n_pass++;
            tick();
        end
    endtask

    // start held high: accepted at cycles 0, 6, 12 -> products 3*7, 1*9, 15*11
    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int c = 0; c < 18; c++) begin
            a4 = ta(c); b4 = tb(c); start4 = 1'b1;
            tick();
            n_chk++; if (busy4 !== ((c % 6) < 4)) $display("FAIL b2b_busy[%0d] got %b want %b", c, busy4, ((c % 6) < 4)); else n_pass++;
            n_chk++; if (done4 !== ((c % 6) == 4)) $display("FAIL b2b_done[%0d] got %b want %b", c, done4, ((c % 6) == 4)); else n_pass++;
            if ((c % 6) == 4) begin
                exp = 8'(ta(c - 4)) * 8'(tb(c - 4));
                n_chk++; if (prod4 !== exp) $display("FAIL b2b_product[%0d] got %0d want %0d", c, prod4, exp); else n_pass++;
            end
        end
        start4 = 1'b0;
        n_chk++; if (prod4 !== 8'd165) $display("FAIL b2b_last_product got %0d want 165", prod4); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        a4 = 4'd7; b4 = 4'd6; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        n_chk++; if (busy4 !== 1'b1) $display("FAIL rstmid_busy_before got %b want 1", busy4); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (busy4 !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy4); else n_pass++;
        n_chk++; if (done4 !== 1'b0) $display("FAIL rstmid_done got %b want 0", done4); else n_pass++;
        n_chk++; if (prod4 !== 8'd0) $display("FAIL rstmid_product got %0d want 0", prod4); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        a4 = 4'd7; b4 = 4'd6; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_chk++; if (done4 !== 1'b1) $display("FAIL rstmid_rerun_done got %b want 1", done4); else n_pass++;
        n_chk++; if (prod4 !== 8'd42) $display("FAIL rstmid_rerun_product got %0d want 42", prod4); else n_pass++;
        tick();
    endtask

    task automatic test_wide();
        logic [7:0]  wa [2];
        logic [7:0]  wb [2];
        logic [15:0] wp [2];
        int nbusy;
        wa[0] = 8'd255; wb[0] = 8'd255; wp[0] = 16'd65025;
        wa[1] = 8'd128; wb[1] = 8'd2;   wp[1] = 16'd256;
        for (int k = 0; k < 2; k++) begin
            a8 = wa[k]; b8 = wb[k]; start8 = 1'b1;
            tick();
            start8 = 1'b0;
            nbusy = 0;
            for (int c = 0; c < 8; c++) begin
                if (busy8) nbusy++;
                tick();
            end
            n_chk++; if (nbusy !== 8) $display("FAIL wide_busy_cycles[%0d] got %0d want 8", k, nbusy); else n_pass++;
            n_chk++; if (done8 !== 1'b1) $display("FAIL wide_done[%0d] got %b want 1", k, done8); else n_pass++;
            n_chk++; if (prod8 !== wp[k]) $display("FAIL wide_product[%0d] got %0d want %0d", k, prod8, wp[k]); else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_back_to_back();
        test_reset_midrun();
        test_wide();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Sequential unsigned N x N shift-and-add multiplier; produces a 2N-bit product in N iterations.
- Sits directly upstream of the multiplying adder (s = a + m*b) and drives its a, b and m inputs.
- Consumes the adder's N-bit sum s each cycle and retires one multiplier bit per cycle.
- The adder is external; this block owns all sequencing, registers and the handshake.

Parameters:
N, 4, operand width in bits (N >= 2); product is 2N bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a_in  input  N  multiplicand, captured when start is accepted
b_in  input  N  multiplier, captured when start is accepted
add_a  output  N  to adder a: current high product half (P_hi)
add_b  output  N  to adder b: registered multiplicand
add_m  output  1  to adder m: P_lo[0] in RUN, 0 otherwise
add_s  input  N  from adder s: add_a + add_m*add_b, truncated to N bits
busy  output  1  high while iterating
done  output  1  one-cycle pulse, product valid
product  output  2N  result, held until the next accepted start

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, P_hi=0, P_lo=0, mcand=0, count=0, busy=0, done=0, product=0. Reset applies immediately, including mid-operation; any in-flight result is discarded.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge -> mcand<=a_in, P_hi<=0, P_lo<=b_in, count<=0, state<=RUN. start=0 -> stay in IDLE.
  - RUN, every edge:
    - carry = (add_s < add_a), unsigned. This is exact, since add_b < 2^N.
    - {P_hi, P_lo} <= {carry, add_s, P_lo[N-1:1]}.
    - count <= count+1.
    - On the edge where count==N-1: state<=DONE, product<={carry, add_s, P_lo[N-1:1]}.
  - DONE: lasts one cycle, then state<=IDLE.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - add_a=P_hi and add_b=mcand at all times; add_m = P_lo[0] & busy.
  - All are combinational from registers. add_s is a pure combinational return path; no registered adder is allowed.
- Latency: start accepted at edge t -> busy high for cycles t..t+N-1 -> done high for the cycle following edge t+N -> next start can be accepted at edge t+N+2.
- start is ignored in RUN and DONE; no queuing.
- product changes only on the final RUN edge or on reset. a_in and b_in may change freely after acceptance.
- Width rules: count is clog2(N)+1 bits. No truncation of the product; the full 2N bits are always produced.
- Zero operands: full N iterations still run; no early termination.

Test Plan:
- N=4, a_in=3, b_in=5, start one cycle -> busy 4 cycles, done pulse, product=15; add_m sequence 1,0,1,0.
- N=4, a_in=15, b_in=15 -> product=225 (0xE1); carry path exercised on iterations 2-4.
- N=4, a_in=0, b_in=9, then a_in=9, b_in=0 -> both product=0, done still after exactly 4 RUN cycles.
- N=4, start held high continuously with changing operands -> accepted only in IDLE; every 6 cycles one done; each product matches the operands captured at acceptance.
- rst_n low during RUN cycle 2 of 7x6 -> busy, done and product return to 0 immediately. A new 7x6 run after release -> 42.
- N=8, a_in=255, b_in=255 -> product=65025 after 8 busy cycles; a_in=128, b_in=2 -> 256.
